// File: rtl/mips_defs.sv
// Shared MIPS fetch definitions: reset fetch address and the
// fetch-sequencer FSM state encoding.
package mips_defs;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] PC_STEP      = 32'd4;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } pc_state_t;

    // Sequential fetch address; 32-bit wrapping add.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/pc_seq_f_if.sv
// Fetch-sequencer bus: D-stage redirect requests and the hazard-unit
// stall in, F-stage fetch address and status out.
// With PC_SEQ_PERF_EN defined the bus also carries redir_cnt/stall_cnt.
interface pc_seq_f_if;

    logic        stall_F;
    logic        br_D;
    logic        j_D;
    logic        jr_D;
    logic [31:0] PC4_D;
    logic [25:0] I26_D;
    logic [31:0] jr_tgt_D;
    logic [31:0] PC_F;
    logic [31:0] PC4_F;
    logic        redir_F;
    logic        pend_F;
    logic        adel_F;
`ifdef PC_SEQ_PERF_EN
    logic [31:0] redir_cnt;
    logic [31:0] stall_cnt;
`endif

    // Sequencer side
    modport slave (
        input  stall_F, br_D, j_D, jr_D, PC4_D, I26_D, jr_tgt_D,
`ifdef PC_SEQ_PERF_EN
        output redir_cnt, stall_cnt,
`endif
        output PC_F, PC4_F, redir_F, pend_F, adel_F
    );

    // Pipeline/hazard-unit side
    modport master (
        output stall_F, br_D, j_D, jr_D, PC4_D, I26_D, jr_tgt_D,
`ifdef PC_SEQ_PERF_EN
        input  redir_cnt, stall_cnt,
`endif
        input  PC_F, PC4_F, redir_F, pend_F, adel_F
    );

endinterface

// File: rtl/npc_D.sv
// D-stage next-PC adder: j target when NPCsrc=1, otherwise the
// PC-relative branch target PC4 + sext(imm16 << 2), wrapping.
module npc_D (
    input  logic        NPCsrc,
    input  logic [31:0] PC4,
    input  logic [25:0] I26,
    output logic [31:0] npc
);

    logic [31:0] br_off;
    logic [31:0] j_tgt;
    logic [31:0] br_tgt;

    assign br_off = {{14{I26[15]}}, I26[15:0], 2'b00};
    assign j_tgt  = {PC4[31:28], I26, 2'b00};
    assign br_tgt = PC4 + br_off;
    assign npc    = NPCsrc ? j_tgt : br_tgt;

endmodule

// File: rtl/pc_seq_f.sv
// Fetch-stage PC sequencer. Applies D-stage redirects (jr > j > br)
// with zero added latency, and buffers a redirect that arrives while
// fetch is stalled so it is applied when the stall releases.
// Optional feature: define PC_SEQ_PERF_EN to add redir_cnt/stall_cnt.
module pc_seq_f
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic       clk,
    input  logic       reset,
    pc_seq_f_if.slave  bus
);

    logic [31:0] npc_tgt;
    logic [31:0] live_tgt;
    logic        req;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] pend_tgt;
    logic [31:0] pend_tgt_nxt;
    logic        redir;
    logic        redir_nxt;
    pc_state_t   state;
    pc_state_t   state_nxt;

    // j_D steers the adder to the jump target, which gives j > br.
    npc_D u_npc (
        .NPCsrc (bus.j_D),
        .PC4    (bus.PC4_D),
        .I26    (bus.I26_D),
        .npc    (npc_tgt)
    );

    assign req      = bus.br_D | bus.j_D | bus.jr_D;
    assign live_tgt = bus.jr_D ? bus.jr_tgt_D : npc_tgt;

    // Next-state, next-PC and buffered-target selection.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        pend_tgt_nxt = pend_tgt;
        redir_nxt    = 1'b0;
        case (state)
            RUN: begin
                if (!bus.stall_F) begin
                    if (req) begin
                        pc_nxt    = live_tgt;
                        redir_nxt = 1'b1;
                    end else begin
                        pc_nxt = pc_plus4(pc);
                    end
                end else if (req) begin
                    pend_tgt_nxt = live_tgt;
                    state_nxt    = PEND;
                end
            end
            PEND: begin
                if (bus.stall_F) begin
                    // Newest redirect replaces the buffered one.
                    if (req) begin
                        pend_tgt_nxt = live_tgt;
                    end
                end else begin
                    // A live redirect is younger than the buffered one.
                    pc_nxt    = req ? live_tgt : pend_tgt;
                    redir_nxt = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    // State, PC and buffered-target registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= RUN;
            pc       <= RESET_PC;
            pend_tgt <= '0;
            redir    <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            pend_tgt <= pend_tgt_nxt;
            redir    <= redir_nxt;
        end
    end

    assign bus.PC_F    = pc;
    assign bus.PC4_F   = pc_plus4(pc);
    assign bus.redir_F = redir;
    assign bus.pend_F  = (state == PEND);
    assign bus.adel_F  = (pc[1:0] != 2'b00);

`ifdef PC_SEQ_PERF_EN
    logic [31:0] redir_cnt;
    logic [31:0] stall_cnt;

    // Wrapping event counters for redirects taken and stalled cycles.
    always_ff @(posedge clk) begin
        if (!reset) begin
            redir_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (redir_nxt) begin
                redir_cnt <= redir_cnt + 32'd1;
            end
            if (bus.stall_F) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign bus.redir_cnt = redir_cnt;
    assign bus.stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_pc_seq_f.sv
// Bench for pc_seq_f: directed redirect/stall/reset scenarios with
// literal expectations, plus a per-cycle compare against a behavioural
// model of the fetch sequencer.
module tb_pc_seq_f;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    pc_seq_f_if bus ();

    pc_seq_f #(.RESET_PC(32'h0000_3000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_redir;
    logic        m_pend;
    logic [31:0] m_ptgt;
    logic        m_chk = 1'b0;
    logic [31:0] m_rcnt;
    logic [31:0] m_scnt;

    function automatic logic [31:0] target_of();
        logic [31:0] off;
        if (bus.jr_D) return bus.jr_tgt_D;
        if (bus.j_D)  return {bus.PC4_D[31:28], bus.I26_D, 2'b00};
        off = {{14{bus.I26_D[15]}}, bus.I26_D[15:0], 2'b00};
        return bus.PC4_D + off;
    endfunction

    // Model update from the fetch rules
    always @(posedge clk) begin
        logic        r;
        logic [31:0] t;
        r = bus.br_D | bus.j_D | bus.jr_D;
        t = target_of();
        m_chk <= 1'b1;
        if (!reset) begin
            m_pc <= 32'h0000_3000; m_redir <= 1'b0; m_pend <= 1'b0;
            m_ptgt <= 32'd0; m_rcnt <= 32'd0; m_scnt <= 32'd0;
        end else if (bus.stall_F) begin
            m_redir <= 1'b0;
            m_scnt  <= m_scnt + 1;
            if (r) begin
                m_pend <= 1'b1;
                m_ptgt <= t;
            end
        end else if (r || m_pend) begin
            m_pc    <= r ? t : m_ptgt;
            m_redir <= 1'b1;
            m_pend  <= 1'b0;
            m_rcnt  <= m_rcnt + 1;
        end else begin
            m_pc    <= m_pc + 32'd4;
            m_redir <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against model away from the active edge
    always @(negedge clk) begin
        if (m_chk) begin
            chk("model_pc",    bus.PC_F,          m_pc);
            chk("model_pc4",   bus.PC4_F,         m_pc + 32'd4);
            chk("model_redir", {31'd0, bus.redir_F}, {31'd0, m_redir});
            chk("model_pend",  {31'd0, bus.pend_F},  {31'd0, m_pend});
            chk("model_adel",  {31'd0, bus.adel_F},  {31'd0, (m_pc[1:0] != 2'b00)});
`ifdef PC_SEQ_PERF_EN
            chk("model_rcnt",  bus.redir_cnt, m_rcnt);
            chk("model_scnt",  bus.stall_cnt, m_scnt);
`endif
        end
    end

    task automatic drive(input logic st, input logic br, input logic j, input logic jr,
                         input logic [31:0] pc4, input logic [25:0] i26, input logic [31:0] jrt);
        bus.stall_F  = st;
        bus.br_D     = br;
        bus.j_D      = j;
        bus.jr_D     = jr;
        bus.PC4_D    = pc4;
        bus.I26_D    = i26;
        bus.jr_tgt_D = jrt;
    endtask

    task automatic idle(input logic st);
        drive(st, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0, 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle(1'b0);

        // Reset for two cycles, then release with no stall
        step(); step();
        chk("rst_pc",    bus.PC_F, 32'h0000_3000);
        chk("rst_pend",  {31'd0, bus.pend_F},  32'd0);
        chk("rst_redir", {31'd0, bus.redir_F}, 32'd0);
        reset = 1'b1;
        step();
        chk("run_3004", bus.PC_F, 32'h0000_3004);
        step();
        chk("run_3008", bus.PC_F, 32'h0000_3008);

        // Taken backward branch: 3008 + (-8) = 3000
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_3008, 26'h000FFFE, 32'd0);
        step();
        chk("br_pc",    bus.PC_F, 32'h0000_3000);
        chk("br_redir", {31'd0, bus.redir_F}, 32'd1);
        idle(1'b0);
        step();
        chk("br_after",       bus.PC_F, 32'h0000_3004);
        chk("br_redir_clear", {31'd0, bus.redir_F}, 32'd0);

        // j under a 3-cycle stall
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_3008, 26'h0000C10, 32'd0);
        step();
        chk("stall_pend1", {31'd0, bus.pend_F}, 32'd1);
        chk("stall_pc1",   bus.PC_F, 32'h0000_3004);
        idle(1'b1);
        step();
        chk("stall_pc2", bus.PC_F, 32'h0000_3004);
        step();
        chk("stall_pend3", {31'd0, bus.pend_F}, 32'd1);
        chk("stall_pc3",   bus.PC_F, 32'h0000_3004);
        idle(1'b0);
        step();
        chk("j_pc",    bus.PC_F, 32'h0000_3040);
        chk("j_pend",  {31'd0, bus.pend_F},  32'd0);
        chk("j_redir", {31'd0, bus.redir_F}, 32'd1);

        // jr beats br
        drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_3044, 26'h0000010, 32'h0000_4000);
        step();
        chk("prio_jr", bus.PC_F, 32'h0000_4000);

        // Newest redirect overwrites the buffered one
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_4004, 26'h0000C10, 32'd0);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'd0, 26'd0, 32'h0000_5000);
        step();
        chk("ovr_hold", bus.PC_F, 32'h0000_4000);
        idle(1'b0);
        step();
        chk("ovr_pc", bus.PC_F, 32'h0000_5000);

        // Reset while a redirect is buffered
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_5004, 26'h0000010, 32'd0);
        step();
        chk("mid_pend", {31'd0, bus.pend_F}, 32'd1);
        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_5004, 26'h0000010, 32'd0);
        step();
        chk("mid_rst_pc",   bus.PC_F, 32'h0000_3000);
        chk("mid_rst_pend", {31'd0, bus.pend_F}, 32'd0);
        reset = 1'b1;
        idle(1'b0);
        step();
        chk("mid_rst_next", bus.PC_F, 32'h0000_3004);

        // Misaligned jr target loads unchanged and flags adel
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 26'd0, 32'h0000_4002);
        step();
        chk("adel_pc",  bus.PC_F, 32'h0000_4002);
        chk("adel_flg", {31'd0, bus.adel_F}, 32'd1);
        idle(1'b0);
        step();
        chk("adel_next", bus.PC_F, 32'h0000_4006);

        // Live redirect wins over buffered one at stall release
        drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_4008, 26'h0000C10, 32'd0);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 26'd0, 32'h0000_6000);
        step();
        chk("live_pc",   bus.PC_F, 32'h0000_6000);
        chk("live_pend", {31'd0, bus.pend_F}, 32'd0);

        // Wrap past the top of the address space
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 26'd0, 32'hFFFF_FFFC);
        step();
        chk("wrap_pc4", bus.PC4_F, 32'h0000_0000);
        idle(1'b0);
        step();
        chk("wrap_pc", bus.PC_F, 32'h0000_0000);

        // Mixed traffic checked by the model
        for (int i = 0; i < 80; i++) begin
            reset = ($urandom_range(0, 39) != 0);
            drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  $urandom, 26'($urandom), $urandom);
            step();
        end
        reset = 1'b1;
        idle(1'b0);
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_seq_f.md
PC_SEQ_F -- requirements
Module: pc_seq_F

Interface
REQ-001 Parameter RESET_PC, 32'h0000_3000, fetch address loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset: sampled on rising clk edge, asserted when 0.
REQ-004 stall_F  input  1  hazard unit freezes fetch; PC_F held while 1.
REQ-005 br_D  input  1  one-cycle pulse, conditional branch resolved taken in D.
REQ-006 j_D  input  1  one-cycle pulse, j/jal in D.
REQ-007 jr_D  input  1  one-cycle pulse, jr/jalr in D.
REQ-008 PC4_D  input  32  PC+4 of the D-stage instruction.
REQ-009 I26_D  input  26  instr[25:0] of the D-stage instruction.
REQ-010 jr_tgt_D  input  32  forwarded rs value for jr/jalr.
REQ-011 PC_F  output  32  current fetch address.
REQ-012 PC4_F  output  32  PC_F+4, combinational.
REQ-013 redir_F  output  1  registered; 1 for the cycle where PC_F was loaded from a redirect target.
REQ-014 pend_F  output  1  registered; 1 while a redirect is buffered in state PEND.
REQ-015 adel_F  output  1  combinational; PC_F[1:0] != 0.

Function
REQ-016 Redirect request r = br_D | j_D | jr_D, with fixed priority jr_D > j_D > br_D when several are asserted.
REQ-017 Targets:
- jr: jr_tgt_D.
- j: {PC4_D[31:28], I26_D, 2'b00}.
- br: PC4_D + sign-extended {I26_D[15:0], 2'b00}.
- All adds are 32-bit wrapping; 32'hFFFF_FFFC + 4 = 0.
REQ-018 Two-state FSM.
- RUN: no stored redirect.
- PEND: holds a 32-bit pend_tgt register.
REQ-019 RUN, stall_F=0, r=0: PC_F <= PC_F+4; redir_F <= 0.
REQ-020 RUN, stall_F=0, r=1: PC_F <= target; redir_F <= 1; zero added latency (delay slot already in F).
REQ-021 RUN, stall_F=1, r=0: PC_F held; redir_F <= 0.
REQ-022 RUN, stall_F=1, r=1: PC_F held; pend_tgt <= target; go to PEND.
REQ-023 PEND, stall_F=1, r=0: hold PC_F and pend_tgt.
REQ-024 PEND, stall_F=1, r=1: pend_tgt overwritten by the new target (newest wins).
REQ-025 PEND, stall_F=0, r=0: PC_F <= pend_tgt; redir_F <= 1; go to RUN.
REQ-026 PEND, stall_F=0, r=1: the live target wins; PC_F <= live target; pend_tgt discarded; go to RUN.
REQ-027 PC_F never changes while stall_F=1.
REQ-028 Misaligned targets are loaded unchanged; adel_F only flags them.

Reset
REQ-029 reset=0 at an edge forces, in every state including PEND:
- PC_F = RESET_PC
- state = RUN
- pend_tgt = 0
- redir_F = 0
- pend_F = 0
REQ-030 reset has priority over stall_F and all redirect inputs.
REQ-031 The first edge with reset=1 and stall_F=0 advances to RESET_PC+4.

Configuration
REQ-032 Macro PC_SEQ_PERF_EN defined: adds outputs redir_cnt[31:0] and stall_cnt[31:0].
- Both reset to 0 and wrap at 2^32.
- redir_cnt increments on each edge where redir_F is set to 1.
- stall_cnt increments on each edge with stall_F=1.
REQ-033 Macro undefined: no counter ports and no counter logic; all other behaviour identical.

Structure
REQ-034 The shared package mips_defs holds:
- RESET_PC default
- FSM state encodings: RUN=1'b0, PEND=1'b1
REQ-035 The branch and j target adders instantiate the existing npc_D as the only sub-module, fed NPCsrc=j_D, PC4=PC4_D, I26=I26_D.
REQ-036 Priority mux and jr selection sit in pc_seq_F.

Verification
REQ-037 Reset sequence: hold reset=0 for 2 cycles, release with no stall -> PC_F = 3000, then 3004, 3008.
REQ-038 Taken branch: PC4_D=3008, I26_D[15:0]=16'hFFFE, br_D pulse, stall_F=0 -> next PC_F = 3000, redir_F=1 for one cycle.
REQ-039 Redirect under stall:
- j_D with I26_D=26'h0000C10 while stall_F=1 for 3 cycles -> pend_F=1 and PC_F held for 3 cycles.
- After the stall drops -> PC_F = 0000_3040, pend_F=0.
REQ-040 Priority and overwrite:
- jr_D and br_D together with jr_tgt_D=0000_4000 -> PC_F = 4000.
- In PEND, new jr to 5000 overwrites the buffered target -> PC_F = 5000 after the stall.
REQ-041 Reset mid-PEND and corner cases:
- reset=0 while pend_F=1 -> PC_F = 3000, pend_F=0; the buffered target is never fetched.
- jr_tgt_D=0000_4002 -> adel_F=1.
- With PC_SEQ_PERF_EN defined, redir_cnt/stall_cnt match the counts of redirects and stalled cycles.
